// File: rtl/mux_select_sequencer.sv
// Walks the 18:1 operand mux through every input for each output neuron of an
// autoencoder layer and hands each operand to the MAC with valid/ready and first/last flags.
module mux_select_sequencer #(
  parameter int N_IN     = 18,
  parameter int SEL_W    = 5,
  parameter int N_NEURON = 3,
  parameter int NIDX_W   = 2,
  parameter int ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ready_in,
  output logic [SEL_W-1:0]  sel,
  output logic [NIDX_W-1:0] neuron_idx,
  output logic [ADDR_W-1:0] weight_addr,
  output logic              valid,
  output logic              first,
  output logic              last,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [SEL_W-1:0]  SEL_LAST  = SEL_W'(N_IN - 1);
  localparam logic [NIDX_W-1:0] NIDX_LAST = NIDX_W'(N_NEURON - 1);

  logic [1:0] state;

  // The weight address advances alongside sel, so it never needs a multiplier;
  // everything is cleared on leaving RUN so the next pass starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sel         <= '0;
      neuron_idx  <= '0;
      weight_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          sel         <= '0;
          neuron_idx  <= '0;
          weight_addr <= '0;
          if (start) state <= RUN;
        end
        RUN: begin
          if (ready_in) begin
            if (sel != SEL_LAST) begin
              sel         <= sel + SEL_W'(1);
              weight_addr <= weight_addr + ADDR_W'(1);
            end else if (neuron_idx != NIDX_LAST) begin
              sel         <= '0;
              neuron_idx  <= neuron_idx + NIDX_W'(1);
              weight_addr <= weight_addr + ADDR_W'(1);
            end else begin
              state       <= DONE;
              sel         <= '0;
              neuron_idx  <= '0;
              weight_addr <= '0;
            end
          end
        end
        DONE: state <= IDLE;
        default: begin
          state       <= IDLE;
          sel         <= '0;
          neuron_idx  <= '0;
          weight_addr <= '0;
        end
      endcase
    end
  end

  // Flags come only from registered state, keeping ready_in off any output path.
  assign valid = (state == RUN);
  assign first = valid && (sel == '0);
  assign last  = valid && (sel == SEL_LAST);
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_mux_select_sequencer.sv
// Self-checking bench for mux_select_sequencer: beat-count reference model with
// per-cycle compare, a transfer scoreboard, and directed literal checks.
module tb_mux_select_sequencer;

  localparam int N_IN     = 18;
  localparam int N_NEURON = 3;
  localparam int BEATS    = N_IN * N_NEURON;

  logic       clk;
  logic       rst;
  logic       start;
  logic       ready_in;
  logic [4:0] sel;
  logic [1:0] neuron_idx;
  logic [5:0] weight_addr;
  logic       valid;
  logic       first;
  logic       last;
  logic       busy;
  logic       done;

  int err_cnt = 0;
  int chk_cnt = 0;

  mux_select_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ready_in   (ready_in),
    .sel        (sel),
    .neuron_idx (neuron_idx),
    .weight_addr(weight_addr),
    .valid      (valid),
    .first      (first),
    .last       (last),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    chk_cnt++;
    if (actual !== expected) begin
      err_cnt++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drives one cycle's inputs, lets them be sampled by one rising edge, and
  // returns 1 time unit later with the outputs settled.
  task automatic applyStimulus(input logic s, input logic r, input logic x);
    start    = s;
    ready_in = r;
    rst      = x;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a pass is just a beat number 0..BEATS-1; phase 0=idle, 1=run, 2=done.
  int  m_phase = 0;
  int  m_beat  = 0;
  bit  started = 0;

  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      m_phase = 0;
      m_beat  = 0;
    end else begin
      case (m_phase)
        0: if (start) begin m_phase = 1; m_beat = 0; end
        1: if (ready_in) begin
             if (m_beat == BEATS - 1) begin m_phase = 2; m_beat = 0; end
             else m_beat++;
           end
        default: m_phase = 0;
      endcase
    end
  end

  // Per-cycle compare against the model, plus the transfer scoreboard.
  int sb_next  = 0;
  int done_cnt = 0;

  always @(negedge clk) begin
    if (started) begin
      checkOutput("model_valid", valid, (m_phase == 1) ? 1 : 0);
      checkOutput("model_busy", busy, (m_phase != 0) ? 1 : 0);
      checkOutput("model_done", done, (m_phase == 2) ? 1 : 0);
      checkOutput("model_sel", sel, (m_phase == 1) ? m_beat % N_IN : 0);
      checkOutput("model_neuron", neuron_idx, (m_phase == 1) ? m_beat / N_IN : 0);
      checkOutput("model_addr", weight_addr, (m_phase == 1) ? m_beat : 0);
      checkOutput("model_first", first, (m_phase == 1 && m_beat % N_IN == 0) ? 1 : 0);
      checkOutput("model_last", last, (m_phase == 1 && m_beat % N_IN == N_IN - 1) ? 1 : 0);
      checkOutput("sel_range", (sel < N_IN) ? 1 : 0, 1);
      if (rst) begin
        sb_next = 0;
      end else begin
        if (valid === 1'b1 && ready_in === 1'b1) begin
          checkOutput("sb_addr_order", weight_addr, sb_next);
          sb_next++;
        end
        if (done === 1'b1) begin
          done_cnt++;
          checkOutput("sb_pass_len", sb_next, BEATS);
          sb_next = 0;
        end
      end
    end
  end

  task automatic waitDone(input string name, input int bound, inout int since);
    int n;
    n = 0;
    while (done !== 1'b1 && n < bound) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      since++;
      n++;
    end
    checkOutput(name, done, 1);
  endtask

  initial begin
    int since;
    int dp0;
    int n;

    start    = 1'b0;
    ready_in = 1'b0;
    rst      = 1'b1;

    // Reset held two cycles with start high
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("rst_sel", sel, 0);
      checkOutput("rst_addr", weight_addr, 0);
      checkOutput("rst_valid", valid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_done", done, 0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("idle_busy", busy, 0);

    // Full pass with ready tied high
    applyStimulus(1'b1, 1'b1, 1'b0);
    since = 1;
    for (int k = 0; k < 54; k++) begin
      checkOutput("full_sel", sel, k % 18);
      checkOutput("full_neuron", neuron_idx, k / 18);
      checkOutput("full_addr", weight_addr, k);
      checkOutput("full_first", first, (k % 18 == 0) ? 1 : 0);
      checkOutput("full_last", last, (k % 18 == 17) ? 1 : 0);
      checkOutput("full_busy", busy, 1);
      applyStimulus(1'b0, 1'b1, 1'b0);
      since++;
    end
    checkOutput("full_done_cycle", since, 55);
    checkOutput("full_done", done, 1);
    checkOutput("full_done_valid", valid, 0);
    checkOutput("full_done_busy", busy, 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("full_idle_busy", busy, 0);
    checkOutput("full_idle_done", done, 0);

    // Backpressure at neuron 1, sel 5
    applyStimulus(1'b1, 1'b1, 1'b0);
    since = 1;
    for (int i = 0; i < 23; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      since++;
    end
    checkOutput("bp_sel_pre", sel, 5);
    checkOutput("bp_neuron_pre", neuron_idx, 1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      since++;
      checkOutput("bp_sel_hold", sel, 5);
      checkOutput("bp_addr_hold", weight_addr, 23);
      checkOutput("bp_valid_hold", valid, 1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    since++;
    checkOutput("bp_sel_next", sel, 6);
    checkOutput("bp_addr_next", weight_addr, 24);
    waitDone("bp_done_seen", 200, since);
    checkOutput("bp_done_cycle", since, 58);
    applyStimulus(1'b0, 1'b1, 1'b0);

    // Start pulses during RUN and DONE are ignored
    dp0 = done_cnt;
    applyStimulus(1'b1, 1'b1, 1'b0);
    since = 1;
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      since++;
    end
    checkOutput("ign_sel9", sel, 9);
    applyStimulus(1'b1, 1'b1, 1'b0);
    since++;
    waitDone("ign_done_seen", 200, since);
    checkOutput("ign_done_cycle", since, 55);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("ign_idle_busy", busy, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("ign_still_idle", busy, 0);
    checkOutput("ign_one_done", done_cnt - dp0, 1);

    // Reset in the middle of neuron 2
    dp0 = done_cnt;
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 45; i++) applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("mr_sel_pre", sel, 9);
    checkOutput("mr_neuron_pre", neuron_idx, 2);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("mr_sel", sel, 0);
    checkOutput("mr_neuron", neuron_idx, 0);
    checkOutput("mr_addr", weight_addr, 0);
    checkOutput("mr_valid", valid, 0);
    checkOutput("mr_busy", busy, 0);
    checkOutput("mr_done", done, 0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("mr_no_done", done_cnt - dp0, 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    since = 1;
    waitDone("mr_fresh_done_seen", 200, since);
    checkOutput("mr_fresh_cycle", since, 55);
    applyStimulus(1'b0, 1'b1, 1'b0);

    // Random ready, start held high for 20 back-to-back passes
    dp0 = done_cnt;
    n = 0;
    while ((done_cnt - dp0) < 20 && n < 10000) begin
      applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b0);
      n++;
    end
    checkOutput("rand_passes", done_cnt - dp0, 20);
    n = 0;
    while (busy !== 1'b0 && n < 200) begin
      applyStimulus(1'b0, 1'b1, 1'b0);
      n++;
    end
    checkOutput("rand_drain_idle", busy, 0);

    applyStimulus(1'b0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
